branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 255 +++++++++++++++++++++++++
 tb/tb_branch_predictor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor and redirect controller for the 5-stage RISC-V
// pipeline. This block is the only source of pc_src, the redirect target and
// the IF/ID and ID/EX flushes. Conditional branches are predicted in ID from a
// table of 2-bit saturating counters and resolved in EX. Mispredictions and
// jumps are redirected from EX. After reset the counter table is initialised
// by a sweep that writes one entry per cycle.
//
// Build option:
//   BP_GSHARE_EN  - when defined, a BHT_IDX-bit global history register is
//                   XORed into the ID lookup index (gshare). When undefined,
//                   indexing uses the PC only.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   id_valid          - ID holds a real instruction
//   id_stall          - ID is held this cycle
//   id_branch         - ID instruction is a conditional branch
//   id_pc, id_target  - PC and decoded branch target of the ID instruction
//   id_pred_taken     - prediction for the ID instruction (carried to EX)
//   id_bht_idx        - table index used for the lookup (carried to EX)
//   ex_valid          - EX holds a real instruction
//   ex_branch/ex_jump - EX instruction is a conditional branch / a jump
//   ex_zero           - branch outcome; taken iff set
//   ex_pc, ex_target  - PC and computed target in EX
//   ex_pred_taken     - prediction carried from ID
//   ex_bht_idx        - table index carried from ID
//   pc_src            - replace the fetch PC with redirect_pc this cycle
//   redirect_pc       - next fetch PC when pc_src is set
//   flush_ifid        - squash IF/ID at the next edge
//   flush_idex        - squash ID/EX at the next edge
//   init_busy         - table sweep in progress
//   mispredict_count  - saturating count of conditional-branch redirects
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int WORD_SIZE   = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int BHT_IDX     = $clog2(BHT_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic                 id_stall,
   input  logic                 id_branch,
   input  logic [WORD_SIZE-1:0] id_pc,
   input  logic [WORD_SIZE-1:0] id_target,
   output logic                 id_pred_taken,
   output logic [BHT_IDX-1:0]   id_bht_idx,
   input  logic                 ex_valid,
   input  logic                 ex_branch,
   input  logic                 ex_jump,
   input  logic                 ex_zero,
   input  logic [WORD_SIZE-1:0] ex_pc,
   input  logic [WORD_SIZE-1:0] ex_target,
   input  logic                 ex_pred_taken,
   input  logic [BHT_IDX-1:0]   ex_bht_idx,
   output logic                 pc_src,
   output logic [WORD_SIZE-1:0] redirect_pc,
   output logic                 flush_ifid,
   output logic                 flush_idex,
   output logic                 init_busy,
   output logic [31:0]          mispredict_count
);

   typedef enum logic {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [BHT_IDX-1:0]   init_ptr_q, init_ptr_d;
   logic [31:0]          mispredict_count_q, mispredict_count_d;

   // Counter table: 2-bit saturating counters, MSB is the prediction.
   logic [1:0]           bht_q [BHT_ENTRIES];

   logic                 bht_we;
   logic [BHT_IDX-1:0]   bht_waddr;
   logic [1:0]           bht_wdata;

   logic [BHT_IDX-1:0]   lookup_idx;
   logic                 pred_raw;
   logic                 ex_mispredict;
   logic                 ex_redirect;
   logic                 id_redirect;
   logic [WORD_SIZE-1:0] ex_redirect_pc;
   logic [1:0]           ctr_cur;
   logic [1:0]           ctr_next;
   logic                 ex_update;

   // Only the index bits of the ID PC take part in the lookup.
   logic                 unused_id_pc_bits;
   assign unused_id_pc_bits = ^{id_pc[WORD_SIZE-1:BHT_IDX+2], id_pc[1:0]};

   // -------------------------------------------------------------------------
   // Global history (gshare build only)
   // -------------------------------------------------------------------------
`ifdef BP_GSHARE_EN
   logic [BHT_IDX-1:0]   ghr_q, ghr_d;

   always_comb begin
      ghr_d = ghr_q;
      if (state_q == S_RUN && ex_update) begin
         ghr_d = {ghr_q[BHT_IDX-2:0], ex_zero};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   assign lookup_idx = id_pc[BHT_IDX+1:2] ^ ghr_q;
`else
   assign lookup_idx = id_pc[BHT_IDX+1:2];
`endif

   // -------------------------------------------------------------------------
   // Shared datapath terms
   // -------------------------------------------------------------------------
   assign ex_update     = ex_valid & ex_branch;
   assign ex_mispredict = ex_update & (ex_zero ^ ex_pred_taken);
   assign ex_redirect   = ex_valid & (ex_jump | ex_mispredict);
   assign pred_raw      = (state_q == S_RUN) & id_branch & bht_q[lookup_idx][1];
   assign id_redirect   = id_valid & ~id_stall & pred_raw;

   // A jump always goes to its target; a mispredicted branch goes to the
   // target if it turned out taken, otherwise to the fall-through.
   assign ex_redirect_pc = (ex_jump | ex_zero) ? ex_target
                                               : ex_pc + WORD_SIZE'(4);

   assign ctr_cur  = bht_q[ex_bht_idx];
   assign ctr_next = ex_zero ? ((ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01)
                             : ((ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= S_INIT;
         init_ptr_q         <= '0;
         mispredict_count_q <= '0;
      end else begin
         state_q            <= state_d;
         init_ptr_q         <= init_ptr_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      init_ptr_d = init_ptr_q;
      unique case (state_q)
         S_INIT: begin
            if (init_ptr_q == BHT_IDX'(BHT_ENTRIES - 1)) begin
               state_d    = S_RUN;
               init_ptr_d = '0;
            end else begin
               init_ptr_d = init_ptr_q + BHT_IDX'(1);
            end
         end
         S_RUN: begin
            state_d = S_RUN;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   // Mispredicts are counted in every state, sticking at all-ones.
   always_comb begin
      mispredict_count_d = mispredict_count_q;
      if (ex_mispredict && (mispredict_count_q != '1)) begin
         mispredict_count_d = mispredict_count_q + 32'd1;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: output logic
   // -------------------------------------------------------------------------
   always_comb begin
      id_pred_taken    = 1'b0;
      id_bht_idx       = '0;
      pc_src           = 1'b0;
      redirect_pc      = '0;
      flush_ifid       = 1'b0;
      flush_idex       = 1'b0;
      init_busy        = 1'b0;
      mispredict_count = mispredict_count_q;
      bht_we           = 1'b0;
      bht_waddr        = '0;
      bht_wdata        = '0;

      if (!rst) begin
         id_pred_taken = pred_raw;
         id_bht_idx    = lookup_idx;

         // EX wins over ID: the ID instruction is squashed by the EX flush.
         if (ex_redirect) begin
            pc_src      = 1'b1;
            redirect_pc = ex_redirect_pc;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
         end else if (id_redirect) begin
            pc_src      = 1'b1;
            redirect_pc = id_target;
            flush_ifid  = 1'b1;
         end

         unique case (state_q)
            S_INIT: begin
               // Sweep writes weakly not-taken; EX updates are discarded.
               init_busy = 1'b1;
               bht_we    = 1'b1;
               bht_waddr = init_ptr_q;
               bht_wdata = 2'b01;
            end
            S_RUN: begin
               bht_we    = ex_update;
               bht_waddr = ex_bht_idx;
               bht_wdata = ctr_next;
            end
            default: begin
               init_busy = 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Counter table storage
   // -------------------------------------------------------------------------
   // NOTE: the table has no reset; its contents are defined by the sweep that
   // follows every reset, which keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (bht_we) begin
         bht_q[bht_waddr] <= bht_wdata;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int WS = 32;
   localparam int N  = 64;
   localparam int IW = 6;

`ifdef BP_GSHARE_EN
   localparam bit GSHARE = 1'b1;
`else
   localparam bit GSHARE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_stall, id_branch;
   logic [WS-1:0] id_pc, id_target;
   logic          id_pred_taken;
   logic [IW-1:0] id_bht_idx;
   logic          ex_valid, ex_branch, ex_jump, ex_zero;
   logic [WS-1:0] ex_pc, ex_target;
   logic          ex_pred_taken;
   logic [IW-1:0] ex_bht_idx;
   logic          pc_src;
   logic [WS-1:0] redirect_pc;
   logic          flush_ifid, flush_idex, init_busy;
   logic [31:0]   mispredict_count;

   branch_predictor #(.WORD_SIZE(WS), .BHT_ENTRIES(N)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_stall(id_stall), .id_branch(id_branch),
      .id_pc(id_pc), .id_target(id_target),
      .id_pred_taken(id_pred_taken), .id_bht_idx(id_bht_idx),
      .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_bht_idx(ex_bht_idx),
      .pc_src(pc_src), .redirect_pc(redirect_pc),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .init_busy(init_busy), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          id_valid, id_stall, id_branch;
      logic [WS-1:0] id_pc, id_target;
      logic          ex_valid, ex_branch, ex_jump, ex_zero;
      logic [WS-1:0] ex_pc, ex_target;
      logic          ex_pred;
      logic [IW-1:0] ex_idx;
   } stim_t;

   typedef struct {
      logic          pc_src;
      logic [WS-1:0] redirect_pc;
      logic          flush_ifid, flush_idex, id_pred_taken, init_busy;
      logic [IW-1:0] id_bht_idx;
      logic [31:0]   mcount;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: counter values as plain integers, a countdown for the
   // sweep, and a saturating mispredict tally.
   int          ctr [N];
   int          init_left;
   logic [31:0] mcount;
   int          ghr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) ctr[i] = 1;
      init_left = N;
      mcount    = '0;
      ghr       = 0;
   endfunction

   function automatic int model_idx(input logic [WS-1:0] pc);
      int i;
      i = int'((pc >> 2) % N);
      if (GSHARE) i = i ^ ghr;
      return i;
   endfunction

   function automatic bit model_pred(input logic [WS-1:0] pc);
      return (init_left == 0) && (ctr[model_idx(pc)] >= 2);
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   // Apply one cycle of stimulus, queue the expected response, then advance
   // the model across the clock edge.
   task automatic step(input stim_t s);
      exp_t e;
      int   idx;
      bit   busy, pred, mis, exr, idr;
      rst = s.rst; id_valid = s.id_valid; id_stall = s.id_stall;
      id_branch = s.id_branch; id_pc = s.id_pc; id_target = s.id_target;
      ex_valid = s.ex_valid; ex_branch = s.ex_branch; ex_jump = s.ex_jump;
      ex_zero = s.ex_zero; ex_pc = s.ex_pc; ex_target = s.ex_target;
      ex_pred_taken = s.ex_pred; ex_bht_idx = s.ex_idx;
      e = '{default: '0};
      mis = 1'b0;
      busy = 1'b0;
      if (s.rst) begin
         model_reset();
      end else begin
         busy = (init_left > 0);
         idx  = model_idx(s.id_pc);
         pred = s.id_branch && !busy && (ctr[idx] >= 2);
         mis  = s.ex_valid && s.ex_branch && (s.ex_zero != s.ex_pred);
         exr  = s.ex_valid && (s.ex_jump || mis);
         idr  = s.id_valid && !s.id_stall && pred;
         e.id_pred_taken = pred;
         e.id_bht_idx    = IW'(idx);
         e.init_busy     = busy;
         e.mcount        = mcount;
         if (exr) begin
            e.pc_src      = 1'b1;
            e.flush_ifid  = 1'b1;
            e.flush_idex  = 1'b1;
            e.redirect_pc = (s.ex_jump || s.ex_zero) ? s.ex_target : s.ex_pc + 32'd4;
         end else if (idr) begin
            e.pc_src      = 1'b1;
            e.flush_ifid  = 1'b1;
            e.redirect_pc = s.id_target;
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      if (!s.rst) begin
         if (mis && mcount != 32'hFFFF_FFFF) mcount = mcount + 32'd1;
         if (busy) begin
            init_left--;
         end else if (s.ex_valid && s.ex_branch) begin
            idx = int'(s.ex_idx);
            if (s.ex_zero) ctr[idx] = (ctr[idx] == 3) ? 3 : ctr[idx] + 1;
            else           ctr[idx] = (ctr[idx] == 0) ? 0 : ctr[idx] - 1;
            if (GSHARE) ghr = ((ghr << 1) | int'(s.ex_zero)) % N;
         end
      end
      #1;
   endtask

   // Resolution of a branch at pc whose prediction was made by the model.
   function automatic stim_t resolve(input logic [WS-1:0] pc, input logic [WS-1:0] tgt,
                                     input logic taken);
      stim_t s;
      s = idle();
      s.ex_valid = 1'b1; s.ex_branch = 1'b1; s.ex_zero = taken;
      s.ex_pc = pc; s.ex_target = tgt;
      s.ex_pred = model_pred(pc);
      s.ex_idx  = IW'(model_idx(pc));
      return s;
   endfunction

   function automatic stim_t lookup(input logic [WS-1:0] pc, input logic [WS-1:0] tgt);
      stim_t s;
      s = idle();
      s.id_valid = 1'b1; s.id_branch = 1'b1; s.id_pc = pc; s.id_target = tgt;
      return s;
   endfunction

   // Monitor: compare every presented response, mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("pc_src", {31'd0, pc_src}, {31'd0, mon_e.pc_src});
         if (mon_e.pc_src) check("redirect_pc", redirect_pc, mon_e.redirect_pc);
         check("flush_ifid", {31'd0, flush_ifid}, {31'd0, mon_e.flush_ifid});
         check("flush_idex", {31'd0, flush_idex}, {31'd0, mon_e.flush_idex});
         check("id_pred_taken", {31'd0, id_pred_taken}, {31'd0, mon_e.id_pred_taken});
         check("id_bht_idx", {26'd0, id_bht_idx}, {26'd0, mon_e.id_bht_idx});
         check("init_busy", {31'd0, init_busy}, {31'd0, mon_e.init_busy});
         check("mispredict_count", mispredict_count, mon_e.mcount);
      end
   end

   initial begin
      stim_t s;
      int    sel;
      rst = 1'b1; id_valid = 0; id_stall = 0; id_branch = 0; id_pc = '0; id_target = '0;
      ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_zero = 0; ex_pc = '0; ex_target = '0;
      ex_pred_taken = 0; ex_bht_idx = '0;
      model_reset();
      @(posedge clk); #1;

      // Reset held with busy inputs: every output must stay 0.
      for (int i = 0; i < 3; i++) begin
         s = lookup(32'h100, 32'h180);
         s.rst = 1'b1; s.ex_valid = 1'b1; s.ex_jump = 1'b1; s.ex_target = 32'h400;
         step(s);
      end

      // Sweep: ID lookup forced not-taken, EX jump redirects, EX update dropped.
      for (int i = 0; i < N; i++) begin
         s = lookup(32'h100, 32'h180);
         if (i == 5) begin
            s.ex_valid = 1'b1; s.ex_jump = 1'b1; s.ex_target = 32'h400;
         end
         if (i == 10) begin
            s.ex_valid = 1'b1; s.ex_branch = 1'b1; s.ex_zero = 1'b1; s.ex_pred = 1'b1;
            s.ex_pc = 32'h100; s.ex_target = 32'h180; s.ex_idx = IW'(model_idx(32'h100));
         end
         step(s);
      end

      // Branch at 0x100 taken twice from not-taken, then predicted taken.
      step(resolve(32'h100, 32'h180, 1'b1));
      step(resolve(32'h100, 32'h180, 1'b1));
      step(lookup(32'h100, 32'h180));

      // Branch at 0x200: train taken, mispredict not-taken, saturate, recover.
      step(resolve(32'h200, 32'h280, 1'b1));
      step(resolve(32'h200, 32'h280, 1'b1));
      step(lookup(32'h200, 32'h280));
      s = resolve(32'h200, 32'h280, 1'b0);
      s.ex_pred = 1'b1;
      step(s);
      for (int i = 0; i < 5; i++) step(resolve(32'h200, 32'h280, 1'b1));
      step(resolve(32'h200, 32'h280, 1'b0));
      step(lookup(32'h200, 32'h280));

      // EX jump collides with an ID predicted-taken redirect.
      s = lookup(32'h100, 32'h80);
      s.ex_valid = 1'b1; s.ex_jump = 1'b1; s.ex_pc = 32'h3F0; s.ex_target = 32'h400;
      step(s);
      step(lookup(32'h100, 32'h80));

      // Reset mid-sweep, with a mispredict counted during the sweep.
      s = idle(); s.rst = 1'b1; step(s);
      for (int i = 0; i < 10; i++) begin
         s = lookup(32'h100, 32'h180);
         if (i == 3) begin
            s.ex_valid = 1'b1; s.ex_branch = 1'b1; s.ex_zero = 1'b0; s.ex_pred = 1'b1;
            s.ex_pc = 32'hFFFF_FFFC; s.ex_idx = 6'd7;
         end
         step(s);
      end
      s = idle(); s.rst = 1'b1; step(s);
      for (int i = 0; i < N + 2; i++) step(lookup(32'h100, 32'h180));
      step(resolve(32'h100, 32'h180, 1'b1));
      step(resolve(32'h100, 32'h180, 1'b1));

      // Reset in RUN, then the full sweep again.
      s = idle(); s.rst = 1'b1; step(s);
      for (int i = 0; i < N + 1; i++) step(lookup(32'h140, 32'h1C0));

      // Alternating outcome at one PC.
      for (int k = 0; k < 24; k++) begin
         s = resolve(32'h300, 32'h380, (k % 2) == 0);
         s.id_valid = 1'b1; s.id_stall = 1'b1; s.id_branch = 1'b1;
         s.id_pc = 32'h300; s.id_target = 32'h380;
         step(s);
      end

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 600; k++) begin
         s = idle();
         s.rst       = ($urandom_range(99) == 0);
         s.id_valid  = $urandom_range(1);
         s.id_stall  = ($urandom_range(3) == 0);
         s.id_branch = $urandom_range(1);
         s.id_pc     = {$urandom_range(255), 2'b00} + 32'h1000;
         s.id_target = $urandom;
         sel = $urandom_range(3);
         s.ex_valid  = ($urandom_range(3) != 0);
         s.ex_jump   = (sel == 1);
         s.ex_branch = (sel >= 2);
         s.ex_zero   = $urandom_range(1);
         s.ex_pc     = $urandom;
         s.ex_target = $urandom;
         s.ex_pred   = $urandom_range(1);
         s.ex_idx    = IW'($urandom_range(N - 1));
         step(s);
      end

      for (int i = 0; i < 3; i++) step(idle());
      @(posedge clk); @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
